cache_port_master: RTL
======================

Name: cache_port_master

Overview:
- Initiator for the 64-bit cache array port (mode/st/in/out). It turns CPU-side word or line requests into correctly sequenced cache accesses.
- Supports single-word and 16-word line transfers, reads and writes.
- Write data and read data each use a valid/ready stream.
- Sits between a core's load/store path and the cache array. It is the only block that drives the array's mode, st and in.

Parameters:
ADDR_W, 32, width of req_addr and c_st
DATA_W, 64, data word width
BURST_LEN, 16, words per line; the word index is st[3:0]
IDLE_MODE, 2'b01, c_mode value driven in every non-access cycle

Ports:
clk  in  1  clock, all state rising-edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request offered
req_ready  out  1  request accepted when high with req_valid at a clock edge
req_write  in  1  1=write, 0=read
req_burst  in  1  1=full line (BURST_LEN words), 0=single word
req_addr  in  ADDR_W  word address; [10:4]=row, [3:0]=word
wr_valid  in  1  write word offered
wr_ready  out  1  write word accepted
wr_data  in  DATA_W  write word
rd_valid  out  1  read word available
rd_ready  in  1  read word consumed
rd_data  out  DATA_W  read word
rd_last  out  1  qualifies final read word of a request
done  out  1  one-cycle pulse at request completion
busy  out  1  high whenever not IDLE
c_mode  out  2  to cache: 11=write, 00=read, IDLE_MODE otherwise
c_st  out  ADDR_W  to cache address
c_wdata  out  DATA_W  to cache write data
c_rdata  in  DATA_W  from cache read data

Behaviour:
- Reset (async, immediate): state=IDLE, c_mode=IDLE_MODE, c_st=0, c_wdata=0, rd_data=0, rd_valid=0, rd_last=0, done=0, busy=0, wr_ready=0.
  - req_ready=1 once rst deasserts.
  - A reset mid-request aborts it with no done pulse.
- All outputs are registered.
- Access rule:
  - Each cache access occupies exactly one cycle with c_mode=11 or 00.
  - The cycle after every access drives c_mode=IDLE_MODE (gap), so repeated accesses to the same address always produce a mode edge.
- Address:
  - c_st[ADDR_W-1:4] = captured req_addr[ADDR_W-1:4], held for the whole request.
  - Word index: single request uses req_addr[3:0]. Burst starts at 0 and increments by 1 through 15 (aligned).
  - The word counter is 4 bits and counts BURST_LEN accesses.
- FSM states: IDLE, WR_WAIT, WR_ACC, RD_ACC, RD_CAPT, RD_HOLD, FIN.
  - IDLE: req_ready=1. On req_valid, capture addr/write/burst and go to WR_WAIT (write) or RD_ACC (read).
  - WR_WAIT: wr_ready=1, c_mode=IDLE_MODE. On wr_valid, register c_wdata=wr_data and c_st, then go to WR_ACC.
  - WR_ACC: c_mode=11 for this one cycle. If last word, go to FIN; else increment index and go to WR_WAIT.
  - RD_ACC: c_mode=00, c_st=current address, then go to RD_CAPT.
  - RD_CAPT: c_mode=IDLE_MODE. Sample c_rdata into rd_data, set rd_valid=1, set rd_last=(last word), go to RD_HOLD.
  - RD_HOLD: hold rd_data/rd_valid/rd_last stable until rd_ready. On handshake, clear rd_valid and go to FIN if last, else increment index and go to RD_ACC.
  - FIN: done=1 for one cycle, then go to IDLE.
- Throughput: write = 2 cycles/word with wr_valid held high; read = 3 cycles/word with rd_ready held high.
- Latency:
  - Single write: access cycle at 2 cycles after accept (with wr_valid already high).
  - Single read: rd_valid at 3 cycles after accept.
- req_ready=0 outside IDLE. Requests offered while busy are ignored, not queued.
- wr_valid outside WR_WAIT is not consumed. rd_ready with rd_valid=0 is ignored.

Optional Feature:
CACHE_CRIT_WORD_FIRST_EN
- Defined: a burst starts at req_addr[3:0] and wraps modulo 16 (e.g. 0xD,0xE,0xF,0x0..0xC). rd_last and done still follow the 16th access.
- Undefined: a burst always starts at word 0 and req_addr[3:0] is ignored for bursts.
- Single-word requests are identical in both builds.

Test Plan:
- Single write then read: write 64'h1111_0000_1111_1111 to addr 32'h0000_0011, then read the same addr.
  - Write: exactly one cycle of c_mode=11 with c_st=32'h11, then c_mode=01.
  - Read: rd_data=64'h1111_0000_1111_1111 with rd_last=1, then done.
- Burst write row 5, word k = 64'hA000+k, then burst read row 5.
  - c_st runs 0x50..0x5F.
  - 16 rd handshakes return A000..A00F in order; rd_last only on A00F.
  - With CACHE_CRIT_WORD_FIRST_EN and addr 0x5D, the read order is A00D, A00E, A00F, A000..A00C.
- Backpressure: burst read with rd_ready low for 5 cycles on word 3.
  - rd_data/rd_valid stay stable.
  - No new c_mode=00 until the handshake; all 16 words are correct.
- Write stall: burst write with wr_valid deasserted for 4 cycles mid-line.
  - c_mode stays 01 during the stall; no duplicate or skipped index.
- Repeated reads to the same addr 0x22: two back-to-back single reads.
  - Each shows c_mode sequence 01→00→01; both return the stored value.
- Reset mid-burst: assert rst during word 7 of a burst write.
  - c_mode=01 and busy=0 immediately (before the next clk edge); no done pulse.
  - req_ready=1 after release; a new single read completes normally.

Source files
------------

// File: rtl/cache_port_master_if.sv
// cache_port_master_if: bundles the CPU-side request/write/read streams and the
// cache array port (mode/st/in/out) of cache_port_master.
//   req_*   : request handshake (valid/ready) with write, burst and word address
//   wr_*    : write-data stream (valid/ready)
//   rd_*    : read-data stream (valid/ready) with rd_last on the final word
//   done    : one-cycle completion pulse, busy: controller not idle
//   c_*     : cache array port (c_mode, c_st, c_wdata out; c_rdata in)
// Modports: master = the controller, slave = the core/cache side.
interface cache_port_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_burst;
  logic [ADDR_W-1:0] req_addr;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              done;
  logic              busy;
  logic [1:0]        c_mode;
  logic [ADDR_W-1:0] c_st;
  logic [DATA_W-1:0] c_wdata;
  logic [DATA_W-1:0] c_rdata;

  modport master (
    input  req_valid, req_write, req_burst, req_addr, wr_valid, wr_data, rd_ready, c_rdata,
    output req_ready, wr_ready, rd_valid, rd_data, rd_last, done, busy, c_mode, c_st, c_wdata
  );

  modport slave (
    output req_valid, req_write, req_burst, req_addr, wr_valid, wr_data, rd_ready, c_rdata,
    input  req_ready, wr_ready, rd_valid, rd_data, rd_last, done, busy, c_mode, c_st, c_wdata
  );
endinterface

// File: rtl/cache_port_master.sv
// cache_port_master: sequences single-word and full-line (BURST_LEN word) reads
// and writes onto the 64-bit cache array port. Every access is one cycle of
// c_mode=11 (write) or 00 (read), always followed by a cycle of IDLE_MODE so
// repeated accesses to one address still produce a mode edge.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   port_io  : cache_port_master_if.master (request, write/read streams, cache port)
// Build option: define CACHE_CRIT_WORD_FIRST_EN to start bursts at req_addr[3:0]
// and wrap modulo 16; otherwise bursts always start at word 0.
//
// state   | meaning
// IDLE    | req_ready high, waiting for a request
// WR_WAIT | wr_ready high, waiting for the next write word
// WR_ACC  | one write access cycle (c_mode=11)
// RD_ACC  | one read access cycle (c_mode=00)
// RD_CAPT | gap cycle, cache read data captured at its end
// RD_HOLD | rd_valid held until rd_ready
// FIN     | done pulse
module cache_port_master #(
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 64,
  parameter int         BURST_LEN = 16,
  parameter logic [1:0] IDLE_MODE = 2'b01
) (
  input logic                   clk,
  input logic                   rst,
  cache_port_master_if.master   port_io
);
  localparam logic [1:0] MODE_WR  = 2'b11;
  localparam logic [1:0] MODE_RD  = 2'b00;
  localparam logic [3:0] LAST_CNT = 4'(BURST_LEN - 1);

  typedef enum logic [2:0] {IDLE, WR_WAIT, WR_ACC, RD_ACC, RD_CAPT, RD_HOLD, FIN} state_t;

  state_t            state_q;
  logic [ADDR_W-5:0] row_q;
  logic [3:0]        idx_q;
  logic [3:0]        cnt_q;
  logic              burst_q;
  logic              req_ready_q, wr_ready_q, rd_valid_q, rd_last_q, done_q, busy_q;
  logic [1:0]        c_mode_q;
  logic [ADDR_W-1:0] c_st_q;
  logic [DATA_W-1:0] c_wdata_q, rd_data_q;

  logic [3:0] idx_d;
  logic [3:0] start_idx;
  logic       is_last;

  always_comb begin
    idx_d   = idx_q + 4'd1;
    // cnt_q counts accesses, independent of where the index started
    is_last = !burst_q || (cnt_q == LAST_CNT);
`ifdef CACHE_CRIT_WORD_FIRST_EN
    start_idx = port_io.req_addr[3:0];
`else
    start_idx = port_io.req_burst ? 4'd0 : port_io.req_addr[3:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      burst_q     <= 1'b0;
      req_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      c_mode_q    <= IDLE_MODE;
      c_st_q      <= '0;
      c_wdata_q   <= '0;
      rd_data_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (port_io.req_valid) begin
            row_q       <= port_io.req_addr[ADDR_W-1:4];
            burst_q     <= port_io.req_burst;
            idx_q       <= start_idx;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (port_io.req_write) begin
              wr_ready_q <= 1'b1;
              state_q    <= WR_WAIT;
            end else begin
              // row_q is not loaded yet, so the first read address comes straight from the request
              c_mode_q <= MODE_RD;
              c_st_q   <= {port_io.req_addr[ADDR_W-1:4], start_idx};
              state_q  <= RD_ACC;
            end
          end
        end
        WR_WAIT: begin
          if (port_io.wr_valid) begin
            wr_ready_q <= 1'b0;
            c_wdata_q  <= port_io.wr_data;
            c_st_q     <= {row_q, idx_q};
            c_mode_q   <= MODE_WR;
            state_q    <= WR_ACC;
          end
        end
        WR_ACC: begin
          c_mode_q <= IDLE_MODE;
          if (is_last) begin
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            idx_q      <= idx_d;
            cnt_q      <= cnt_q + 4'd1;
            wr_ready_q <= 1'b1;
            state_q    <= WR_WAIT;
          end
        end
        RD_ACC: begin
          c_mode_q <= IDLE_MODE;
          state_q  <= RD_CAPT;
        end
        RD_CAPT: begin
          rd_data_q  <= port_io.c_rdata;
          rd_valid_q <= 1'b1;
          rd_last_q  <= is_last;
          state_q    <= RD_HOLD;
        end
        RD_HOLD: begin
          if (port_io.rd_ready) begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            if (is_last) begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              idx_q    <= idx_d;
              cnt_q    <= cnt_q + 4'd1;
              c_st_q   <= {row_q, idx_d};
              c_mode_q <= MODE_RD;
              state_q  <= RD_ACC;
            end
          end
        end
        FIN: begin
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          c_mode_q    <= IDLE_MODE;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
          wr_ready_q  <= 1'b0;
          rd_valid_q  <= 1'b0;
          rd_last_q   <= 1'b0;
        end
      endcase
    end
  end

  assign port_io.req_ready = req_ready_q;
  assign port_io.wr_ready  = wr_ready_q;
  assign port_io.rd_valid  = rd_valid_q;
  assign port_io.rd_data   = rd_data_q;
  assign port_io.rd_last   = rd_last_q;
  assign port_io.done      = done_q;
  assign port_io.busy      = busy_q;
  assign port_io.c_mode    = c_mode_q;
  assign port_io.c_st      = c_st_q;
  assign port_io.c_wdata   = c_wdata_q;
endmodule
